fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have port i_clk  input  1  the single clock, rising-edge.
REQ-003 SHALL have port in_rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port o_imem_pc  output  32  fetch address driven to the combinational-read instruction memory.
REQ-005 SHALL have port i_imem_instr  input  32  instruction word returned for o_imem_pc in the same cycle.
REQ-006 SHALL have port i_stall  input  1  decode not ready; hold PC and the IF/ID register.
REQ-007 SHALL have port i_flush  input  1  kill the IF/ID entry.
REQ-008 SHALL have port i_redirect / i_redirect_pc  input  1 / 32  branch or jump request and its target.
REQ-009 SHALL have port i_trap / i_trap_pc  input  1 / 32  interrupt or exception entry and its vector from the interrupt handler.
REQ-010 SHALL have port i_wfi  input  1  wait-for-interrupt request from decode.
REQ-011 SHALL have port o_valid / o_instr / o_pc / o_pc4  output  1 / 32 / 32 / 32  IF/ID register contents.
REQ-012 SHALL have port o_sleep  output  1  high while in state SLEEP.

Function
REQ-013 SHALL hold pc_q and drive o_imem_pc = pc_q combinationally.
REQ-014 SHALL implement states BOOT, RUN and SLEEP; BOOT SHALL last exactly one cycle with o_valid=0 and no PC advance, then go to RUN.
REQ-015 SHALL apply this priority in RUN each cycle: i_trap > i_redirect > i_stall > i_wfi > sequential.
REQ-016 In sequential mode it SHALL, at the edge, load IF/ID with {valid=1, instr=i_imem_instr, pc=pc_q, pc4=pc_q+4} and set pc_q <= pc_q+4.
REQ-017 On i_trap it SHALL set pc_q <= i_trap_pc and o_valid <= 0, overriding i_stall, i_flush, i_redirect and i_wfi.
REQ-018 On i_redirect without i_trap it SHALL set pc_q <= i_redirect_pc and o_valid <= 0, even when i_stall=1.
REQ-019 On i_stall without trap or redirect it SHALL hold pc_q and all IF/ID fields, except that i_flush=1 clears o_valid.
REQ-020 On i_flush without stall, trap or redirect it SHALL clear o_valid at the next edge while pc_q still advances by 4.
REQ-021 On i_wfi in RUN without higher-priority events it SHALL go to SLEEP, hold pc_q at the instruction after WFI, and set o_valid <= 0.
REQ-022 In SLEEP it SHALL keep o_valid=0, hold pc_q and ignore i_redirect, i_stall and i_flush; i_trap SHALL load i_trap_pc and return to RUN.
REQ-023 PC arithmetic SHALL be modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-024 It SHALL always force bits [1:0] of any loaded target to 2'b00.

Reset
REQ-025 While in_rst=0, asynchronously: pc_q=RESET_PC, state=BOOT, o_valid=0, o_instr=32'h0000_0013 (NOP), o_pc=RESET_PC, o_pc4=RESET_PC+4, o_sleep=0.
REQ-026 Reset asserted mid-operation, including in SLEEP or during a redirect, SHALL abandon all in-flight state with no residual effect after release.

Configuration
REQ-027 Macro FETCH_MISALIGN_EN: when defined, it SHALL add output o_misalign (1 bit) and pulse it high for one cycle, aligned with o_valid=0, when a redirect or trap target has bits [1:0] != 0, with o_pc holding the raw unaligned target; when undefined, the port SHALL be absent and misaligned targets SHALL be silently aligned per REQ-024.

Verification
REQ-028 Reset release with RESET_PC=0 -> one BOOT cycle with o_valid=0, then o_imem_pc sequence 0, 4, 8 with o_pc trailing by one cycle and o_valid=1.
REQ-029 i_stall high for 3 cycles at pc_q=0x10 -> o_imem_pc stays 0x10 and o_instr/o_pc stay unchanged; resumes at 0x14 after release.
REQ-030 i_redirect=1 with i_redirect_pc=0x200 while i_stall=1 -> next cycle o_imem_pc=0x200 and o_valid=0; the following cycle o_pc=0x200 and o_valid=1.
REQ-031 i_trap (i_trap_pc=0x100) in the same cycle as i_redirect (0x300) -> pc_q=0x100 and o_valid=0.
REQ-032 i_wfi at pc_q=0x40 -> o_sleep=1 with pc held at 0x40; i_redirect ignored; i_trap to 0x100 -> o_sleep=0 and fetch resumes at 0x100.
REQ-033 pc_q=0xFFFF_FFFC in sequential mode -> next o_imem_pc=0x0 and o_pc4=0x0; with FETCH_MISALIGN_EN defined, redirect to 0x202 -> o_misalign=1 for one cycle, o_pc=0x202, pc_q=0x200.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, BOOT/RUN/SLEEP control and IF/ID pipeline register.
// Optional FETCH_MISALIGN_EN adds o_misalign, flagging redirect/trap targets with nonzero low bits.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        in_rst,
  output logic [31:0] o_imem_pc,
  input  logic [31:0] i_imem_instr,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_trap,
  input  logic [31:0] i_trap_pc,
  input  logic        i_wfi,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4,
  output logic        o_sleep
`ifdef FETCH_MISALIGN_EN
  ,
  output logic        o_misalign
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    SLEEP
  } state_t;

  state_t      state_q, state_n;
  logic [31:0] pc_q, pc_n;
  logic        valid_q, valid_n;
  logic [31:0] instr_q, instr_n;
  logic [31:0] idpc_q, idpc_n;
  logic [31:0] pc4_q, pc4_n;
  logic        mis_q, mis_n;
  logic [31:0] pc_plus4;
  logic [31:0] target_raw;

  assign pc_plus4   = pc_q + 32'd4;
  assign target_raw = i_trap ? i_trap_pc : i_redirect_pc;

  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    valid_n = valid_q;
    instr_n = instr_q;
    idpc_n  = idpc_q;
    pc4_n   = pc4_q;
    mis_n   = 1'b0;
    unique case (state_q)
      BOOT: begin
        valid_n = 1'b0;
        state_n = RUN;
      end
      RUN: begin
        if (i_trap || i_redirect) begin
          pc_n    = {target_raw[31:2], 2'b00};
          valid_n = 1'b0;
          if (target_raw[1:0] != 2'b00) begin
            mis_n  = 1'b1;
            // o_pc only reports the raw target when the misalign flag exists to qualify it
`ifdef FETCH_MISALIGN_EN
            idpc_n = target_raw;
`endif
          end
        end else if (i_stall) begin
          if (i_flush) valid_n = 1'b0;
        end else if (i_wfi) begin
          valid_n = 1'b0;
          state_n = SLEEP;
        end else begin
          valid_n = ~i_flush;
          instr_n = i_imem_instr;
          idpc_n  = pc_q;
          pc4_n   = pc_plus4;
          pc_n    = pc_plus4;
        end
      end
      SLEEP: begin
        valid_n = 1'b0;
        if (i_trap) begin
          pc_n    = {i_trap_pc[31:2], 2'b00};
          state_n = RUN;
          if (i_trap_pc[1:0] != 2'b00) begin
            mis_n  = 1'b1;
`ifdef FETCH_MISALIGN_EN
            idpc_n = i_trap_pc;
`endif
          end
        end
      end
      default: state_n = BOOT;
    endcase
  end

  always_ff @(posedge i_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP;
      idpc_q  <= RESET_PC;
      pc4_q   <= RESET_PC + 32'd4;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      valid_q <= valid_n;
      instr_q <= instr_n;
      idpc_q  <= idpc_n;
      pc4_q   <= pc4_n;
      mis_q   <= mis_n;
    end
  end

  assign o_imem_pc = pc_q;
  assign o_valid   = valid_q;
  assign o_instr   = instr_q;
  assign o_pc      = idpc_q;
  assign o_pc4     = pc4_q;
  assign o_sleep   = (state_q == SLEEP);

`ifdef FETCH_MISALIGN_EN
  assign o_misalign = mis_q;
`else
  logic unused_mis;
  assign unused_mis = mis_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; instruction memory returns a fixed function of the address.
// Define FETCH_MISALIGN_EN to also exercise o_misalign.
module tb_fetch_unit;

  logic        i_clk = 1'b0;
  logic        in_rst;
  logic [31:0] o_imem_pc;
  logic [31:0] i_imem_instr;
  logic        i_stall, i_flush, i_redirect, i_trap, i_wfi;
  logic [31:0] i_redirect_pc, i_trap_pc;
  logic        o_valid, o_sleep;
  logic [31:0] o_instr, o_pc, o_pc4;
`ifdef FETCH_MISALIGN_EN
  logic        o_misalign;
`endif

  int ntotal = 0;
  int nbad   = 0;

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], 16'hC0DE} ^ 32'h0BAD_0000;
  endfunction

  assign i_imem_instr = mem(o_imem_pc);

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk(i_clk), .in_rst(in_rst),
    .o_imem_pc(o_imem_pc), .i_imem_instr(i_imem_instr),
    .i_stall(i_stall), .i_flush(i_flush),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .i_trap(i_trap), .i_trap_pc(i_trap_pc), .i_wfi(i_wfi),
    .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc), .o_pc4(o_pc4),
    .o_sleep(o_sleep)
`ifdef FETCH_MISALIGN_EN
    , .o_misalign(o_misalign)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntotal++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_stall = 0; i_flush = 0; i_redirect = 0; i_trap = 0; i_wfi = 0;
  endtask

  task automatic chk_reset_vals(input string t);
    check({t, "_pc"},    o_imem_pc, 32'h0);
    check({t, "_valid"}, {31'b0, o_valid}, 32'h0);
    check({t, "_instr"}, o_instr, 32'h0000_0013);
    check({t, "_opc"},   o_pc, 32'h0);
    check({t, "_pc4"},   o_pc4, 32'h4);
    check({t, "_sleep"}, {31'b0, o_sleep}, 32'h0);
  endtask

  initial begin
    idle();
    i_redirect_pc = '0; i_trap_pc = '0;
    in_rst = 1'b0;
    #12;
    chk_reset_vals("rst");
    @(negedge i_clk); in_rst = 1'b1;

    // boot cycle, then sequential 0,4,8
    step();
    check("boot_pc", o_imem_pc, 32'h0);
    check("boot_valid", {31'b0, o_valid}, 32'h0);
    step();
    check("seq0_pc", o_imem_pc, 32'h4);
    check("seq0_opc", o_pc, 32'h0);
    check("seq0_valid", {31'b0, o_valid}, 32'h1);
    check("seq0_instr", o_instr, mem(32'h0));
    check("seq0_pc4", o_pc4, 32'h4);
    step();
    check("seq1_pc", o_imem_pc, 32'h8);
    check("seq1_opc", o_pc, 32'h4);
    step(); step();
    check("pre_stall_pc", o_imem_pc, 32'h10);

    // stall for 3 cycles
    i_stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", o_imem_pc, 32'h10);
      check("stall_opc", o_pc, 32'hC);
      check("stall_instr", o_instr, mem(32'hC));
      check("stall_valid", {31'b0, o_valid}, 32'h1);
    end
    idle(); step();
    check("unstall_pc", o_imem_pc, 32'h14);
    check("unstall_opc", o_pc, 32'h10);

    // redirect wins over stall
    i_stall = 1; i_redirect = 1; i_redirect_pc = 32'h200;
    step();
    check("redir_pc", o_imem_pc, 32'h200);
    check("redir_valid", {31'b0, o_valid}, 32'h0);
    idle(); step();
    check("redir_opc", o_pc, 32'h200);
    check("redir_valid2", {31'b0, o_valid}, 32'h1);
    check("redir_pc2", o_imem_pc, 32'h204);

    // flush without stall advances PC
    i_flush = 1; step();
    check("flush_valid", {31'b0, o_valid}, 32'h0);
    check("flush_pc", o_imem_pc, 32'h208);
    // flush during stall holds PC
    i_flush = 1; i_stall = 1; step();
    check("sflush_valid", {31'b0, o_valid}, 32'h0);
    check("sflush_pc", o_imem_pc, 32'h208);
    idle(); step();
    check("sflush_opc", o_pc, 32'h208);
    check("sflush_valid2", {31'b0, o_valid}, 32'h1);

    // trap beats everything
    i_trap = 1; i_trap_pc = 32'h100; i_redirect = 1; i_redirect_pc = 32'h300;
    i_stall = 1; i_wfi = 1; i_flush = 1;
    step();
    check("trap_pc", o_imem_pc, 32'h100);
    check("trap_valid", {31'b0, o_valid}, 32'h0);
    check("trap_sleep", {31'b0, o_sleep}, 32'h0);
    idle(); step();
    check("trap_opc", o_pc, 32'h100);

    // WFI at 0x40
    i_redirect = 1; i_redirect_pc = 32'h40; step();
    idle(); i_wfi = 1; step();
    check("wfi_sleep", {31'b0, o_sleep}, 32'h1);
    check("wfi_pc", o_imem_pc, 32'h40);
    check("wfi_valid", {31'b0, o_valid}, 32'h0);
    idle(); i_redirect = 1; i_redirect_pc = 32'h300; i_stall = 1; i_flush = 1;
    step(); step();
    check("sleep_ign_pc", o_imem_pc, 32'h40);
    check("sleep_ign_sleep", {31'b0, o_sleep}, 32'h1);
    check("sleep_ign_valid", {31'b0, o_valid}, 32'h0);
    idle(); i_trap = 1; i_trap_pc = 32'h100; step();
    check("wake_sleep", {31'b0, o_sleep}, 32'h0);
    check("wake_pc", o_imem_pc, 32'h100);
    idle(); step();
    check("wake_opc", o_pc, 32'h100);
    check("wake_valid", {31'b0, o_valid}, 32'h1);

    // misaligned target is aligned
    i_redirect = 1; i_redirect_pc = 32'h203; step();
    check("align_pc", o_imem_pc, 32'h200);
    idle();
`ifdef FETCH_MISALIGN_EN
    check("align_mis", {31'b0, o_misalign}, 32'h1);
    check("align_rawpc", o_pc, 32'h203);
`endif

    // wraparound
    i_redirect = 1; i_redirect_pc = 32'hFFFF_FFFC; step();
    idle(); step();
    check("wrap_pc", o_imem_pc, 32'h0);
    check("wrap_opc", o_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", o_pc4, 32'h0);

`ifdef FETCH_MISALIGN_EN
    i_redirect = 1; i_redirect_pc = 32'h202; step();
    check("mis_flag", {31'b0, o_misalign}, 32'h1);
    check("mis_opc", o_pc, 32'h202);
    check("mis_pc", o_imem_pc, 32'h200);
    check("mis_valid", {31'b0, o_valid}, 32'h0);
    idle(); step();
    check("mis_flag_clr", {31'b0, o_misalign}, 32'h0);
`endif

    // reset during SLEEP
    i_redirect = 1; i_redirect_pc = 32'h80; step();
    idle(); i_wfi = 1; step();
    check("pre_rst_sleep", {31'b0, o_sleep}, 32'h1);
    in_rst = 1'b0; #1;
    chk_reset_vals("rst_sleep");
    // reset with a pending redirect
    i_wfi = 0; i_redirect = 1; i_redirect_pc = 32'h400;
    step();
    chk_reset_vals("rst_hold");
    idle();
    @(negedge i_clk); in_rst = 1'b1;
    step();
    check("rboot_pc", o_imem_pc, 32'h0);
    check("rboot_valid", {31'b0, o_valid}, 32'h0);
    check("rboot_sleep", {31'b0, o_sleep}, 32'h0);
    step();
    check("rrun_pc", o_imem_pc, 32'h4);
    check("rrun_opc", o_pc, 32'h0);
    check("rrun_valid", {31'b0, o_valid}, 32'h1);

    $display("test done: total=%0d bad=%0d", ntotal, nbad);
    $finish;
  end

endmodule
